// File: rtl/lb_byte_sequencer.sv
// lb_byte_sequencer: runs an NBYTES-wide operation through one 8-bit
// logicBlock, one byte slice per clock, LSB first, with the Co chained.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              request, sampled only in IDLE
//   op_a, op_b         wide operands, latched on an accepted start
//   mode, cin          logicBlock m code and carry into slice 0
//   busy, done         busy in RUN/DONE; done pulses for one cycle
//   result, cout       assembled W bytes and final Co, held until next start
//   lb_a, lb_b         byte slice driven to the logicBlock
//   lb_m, lb_ci        latched m code and chained carry to the logicBlock
//   lb_w, lb_co        logicBlock outputs for the current slice
module lb_byte_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic [1:0]            mode,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic [7:0]            lb_a,
    output logic [7:0]            lb_b,
    output logic [1:0]            lb_m,
    output logic                  lb_ci,
    input  logic [7:0]            lb_w,
    input  logic                  lb_co
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [1:0]    m_q;
    logic          last;

    assign last = (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        lb_a      = '0;
        lb_b      = '0;
        lb_m      = '0;
        lb_ci     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                // {idx,3'b000} is the bit offset of byte idx
                lb_a  = a_q[{idx, 3'b000} +: 8];
                lb_b  = b_q[{idx, 3'b000} +: 8];
                lb_m  = m_q;
                lb_ci = carry;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= op_a;
                        b_q    <= op_b;
                        m_q    <= mode;
                        carry  <= cin;
                        idx    <= '0;
                        result <= '0;
                        cout   <= 1'b0;
                    end
                end
                RUN: begin
                    result[{idx, 3'b000} +: 8] <= lb_w;
                    carry <= lb_co;
                    if (last) begin
                        cout <= lb_co;
                        idx  <= '0;
                    end else begin
                        idx  <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lb_byte_sequencer.sv
// tb_lb_byte_sequencer: table vectors, hand sequences and randomized
// back-to-back ops checked against a wide-arithmetic reference model.
module tb_lb_byte_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [1:0]    mode;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic [7:0]    lb_a;
    logic [7:0]    lb_b;
    logic [1:0]    lb_m;
    logic          lb_ci;
    logic [7:0]    lb_w;
    logic          lb_co;
    bit            real_lb = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lb_byte_sequencer #(.NBYTES(NB)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .mode   (mode),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .lb_a   (lb_a),
        .lb_b   (lb_b),
        .lb_m   (lb_m),
        .lb_ci  (lb_ci),
        .lb_w   (lb_w),
        .lb_co  (lb_co)
    );

    // logicBlock stand-in: {Co, W}. The adder stub is mode 0.
    function automatic logic [8:0] lb_fn(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [1:0] m,
                                         input logic ci);
        logic [8:0] r;
        case (m)
            2'd0:    r = {1'b0, a} + {1'b0, b} + {8'd0, ci};
            2'd1:    r = {ci, a & b};
            2'd2:    r = {1'b0, a | b} + {8'd0, ci};
            default: r = {ci, a ^ b};
        endcase
        return r;
    endfunction

    assign {lb_co, lb_w} = lb_fn(lb_a, lb_b, real_lb ? lb_m : 2'd0, lb_ci);

    // Reference: whole-operand arithmetic; mode 2 walks the bytes.
    function automatic logic [W:0] gold(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [1:0] m,
                                        input logic ci);
        logic [W:0]   r;
        logic [W-1:0] v;
        logic [8:0]   s;
        logic         c;
        case (m)
            2'd0: r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            2'd1: r = {ci, a & b};
            2'd3: r = {ci, a ^ b};
            default: begin
                v = a | b;
                c = ci;
                r = '0;
                for (int i = 0; i < NB; i++) begin
                    s = {1'b0, v[i*8 +: 8]} + {8'd0, c};
                    r[i*8 +: 8] = s[7:0];
                    c = s[8];
                end
                r[W] = c;
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start from IDLE; record per-cycle lb_ci/lb_a and done timing.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] m, input logic c,
                          output int dcyc, output int dcnt,
                          output logic [NB-1:0] cis,
                          output logic [W-1:0] las);
        op_a  = a;
        op_b  = b;
        mode  = m;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        dcyc  = -1;
        dcnt  = 0;
        cis   = '0;
        las   = '0;
        for (int k = 1; k <= NB + 3; k++) begin
            if (k <= NB) begin
                cis[k-1] = lb_ci;
                las[(k-1)*8 +: 8] = lb_a;
            end
            if (done) begin
                dcnt++;
                if (dcyc < 0) dcyc = k;
            end
            tick();
        end
    endtask

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          c;
        logic [W-1:0]  res;
        logic          co;
        logic [NB-1:0] cis;
    } vec_t;

    vec_t          tbl[5];
    int            dcyc;
    int            dcnt;
    logic [NB-1:0] cis;
    logic [W-1:0]  las;
    logic [W-1:0]  ra[11];
    logic [W-1:0]  rb[11];
    logic [1:0]    rm[11];
    logic          rc[11];
    logic [W:0]    g;
    int            nd;

    initial begin
        tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0,
                   32'h00000100, 1'b0, 4'b0010};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1,
                   32'h00000000, 1'b1, 4'b1111};
        tbl[2] = '{32'h12345678, 32'h11111111, 1'b0,
                   32'h23456789, 1'b0, 4'b0000};
        tbl[3] = '{32'h80000000, 32'h80000000, 1'b0,
                   32'h00000000, 1'b1, 4'b0000};
        tbl[4] = '{32'h00FF00FF, 32'h00010001, 1'b0,
                   32'h01000100, 1'b0, 4'b1010};

        rst   = 1'b1;
        start = 1'b1;
        op_a  = 32'hDEADBEEF;
        op_b  = 32'hCAFEF00D;
        mode  = 2'd0;
        cin   = 1'b1;

        // reset with start asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_busy_done", {busy, done}, 2'b00);
            chk("rst_result", result, 0);
            chk("rst_cout", cout, 0);
            chk("rst_lb", {lb_a, lb_b, lb_m, lb_ci}, 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // table vectors, adder stub
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, 2'd0, tbl[i].c,
                   dcyc, dcnt, cis, las);
            chk($sformatf("v%0d_result", i), result, tbl[i].res);
            chk($sformatf("v%0d_cout", i), cout, tbl[i].co);
            chk($sformatf("v%0d_lbci", i), cis, tbl[i].cis);
            chk($sformatf("v%0d_lba", i), las, tbl[i].a);
            chk($sformatf("v%0d_donecyc", i), dcyc, 5);
            chk($sformatf("v%0d_donecnt", i), dcnt, 1);
            chk($sformatf("v%0d_idle_lb", i),
                {busy, lb_a, lb_b, lb_m, lb_ci}, 0);
        end

        // second start during RUN and DONE is ignored
        op_a  = 32'h12345678;
        op_b  = 32'h11111111;
        mode  = 2'd0;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        op_a  = 32'hFFFFFFFF;
        op_b  = 32'hFFFFFFFF;
        tick();
        tick();
        tick();
        chk("t4_done", done, 1);
        chk("t4_result", result, 32'h23456789);
        chk("t4_cout", cout, 0);
        start = 1'b0;
        tick();
        chk("t4_idle", {busy, done}, 2'b00);
        chk("t4_hold", result, 32'h23456789);

        // reset in the middle of RUN
        op_a  = 32'h12345678;
        op_b  = 32'h11111111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t5_busy_mid", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_result", result, 0);
        chk("t5_cout", cout, 0);
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) nd++;
            tick();
        end
        chk("t5_nodone", nd, 0);
        run_op(32'h1, 32'h1, 2'd0, 1'b0, dcyc, dcnt, cis, las);
        chk("t5_fresh", result, 32'h2);
        chk("t5_fresh_done", dcnt, 1);

        // random back-to-back ops, start held high, all modes
        real_lb = 1'b1;
        for (int i = 0; i < 11; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rm[i] = 2'($urandom_range(0, 3));
            rc[i] = 1'($urandom_range(0, 1));
        end
        op_a  = ra[0];
        op_b  = rb[0];
        mode  = rm[0];
        cin   = rc[0];
        start = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            op_a = ra[i+1];
            op_b = rb[i+1];
            mode = rm[i+1];
            cin  = rc[i+1];
            g    = gold(ra[i], rb[i], rm[i], rc[i]);
            for (int k = 1; k <= 6; k++) begin
                if (k == 1) chk($sformatf("r%0d_accept", i), busy, 1);
                if (k == 1) chk($sformatf("r%0d_lbm", i), lb_m, rm[i]);
                if (k == 5) begin
                    chk($sformatf("r%0d_done", i), done, 1);
                    chk($sformatf("r%0d_result", i), result, g[W-1:0]);
                    chk($sformatf("r%0d_cout", i), cout, g[W]);
                end
                if (k == 6) chk($sformatf("r%0d_idle", i), busy, 0);
                tick();
            end
        end
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("end_idle", {busy, done}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
